riscv_seq_ctrl: RTL and testbench

Multi-cycle sequencer for the RV32I core.
- Owns the PC.
- Fetches instructions over a valid/ready instruction-memory port.
- Latches each instruction into a register that drives the field decoder.
- Classifies the opcode and steps the datapath through EXEC/MEM/WB with one-cycle write-enable pulses.
- Sits between the memory ports and the decoder/regfile/ALU datapath.

---
 rtl/riscv_seq_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_riscv_seq_ctrl.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_seq_ctrl.sv
// Multi-cycle RV32I sequencer: owns the PC, fetches over valid/ready, classifies the opcode and
// steps the datapath through EXEC/MEM/WB. Optional retire counter: RISCV_SEQ_CTRL_INSTRET_EN.
module riscv_seq_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic [31:0] insn,
    input  logic [6:0]  opcode,
    output logic [31:0] pc,
    input  logic [31:0] pc_next,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    input  logic        dmem_resp_valid,
    output logic        rf_we,
    output logic        pc_we,
    output logic [2:0]  state,
`ifdef RISCV_SEQ_CTRL_INSTRET_EN
    output logic [63:0] instret,
`endif
    output logic        trap,
    output logic        halted
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_WAIT_I = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WAIT_D = 3'd5,
        ST_WB     = 3'd6,
        ST_STOP   = 3'd7
    } state_t;

    localparam logic [31:0] NOP_INSN    = 32'h0000_0013;
    localparam logic [7:0]  TIMEOUT_CNT = 8'(TIMEOUT);

    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg;
    logic [31:0] insn_reg, insn_next;
    logic        trap_reg, trap_next;
    logic        halted_reg, halted_next;
    logic [7:0]  cnt_reg, cnt_next;
    logic        is_mem_reg, is_mem_next;
    logic        is_wr_reg, is_wr_next;
    logic        is_sys_reg, is_sys_next;
    logic        wait_tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_FETCH;
            pc_reg     <= RESET_PC;
            insn_reg   <= NOP_INSN;
            trap_reg   <= 1'b0;
            halted_reg <= 1'b0;
            cnt_reg    <= 8'd0;
            is_mem_reg <= 1'b0;
            is_wr_reg  <= 1'b0;
            is_sys_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            insn_reg   <= insn_next;
            trap_reg   <= trap_next;
            halted_reg <= halted_next;
            cnt_reg    <= cnt_next;
            is_mem_reg <= is_mem_next;
            is_wr_reg  <= is_wr_next;
            is_sys_reg <= is_sys_next;
            if (state_reg == ST_WB) begin
                pc_reg <= pc_next;
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        insn_next   = insn_reg;
        trap_next   = trap_reg;
        halted_next = halted_reg;
        is_mem_next = is_mem_reg;
        is_wr_next  = is_wr_reg;
        is_sys_next = is_sys_reg;
        wait_tick   = 1'b0;
        cnt_next    = 8'd0;
        case (state_reg)
            ST_FETCH: begin
                if (imem_req_ready) begin
                    if (imem_resp_valid) begin
                        insn_next  = imem_resp_data;
                        state_next = ST_DECODE;
                    end else begin
                        state_next = ST_WAIT_I;
                    end
                end else begin
                    wait_tick = 1'b1;
                end
            end
            ST_WAIT_I: begin
                if (imem_resp_valid) begin
                    insn_next  = imem_resp_data;
                    state_next = ST_DECODE;
                end else begin
                    wait_tick = 1'b1;
                end
            end
            ST_DECODE: begin
                is_mem_next = 1'b0;
                is_wr_next  = 1'b0;
                is_sys_next = 1'b0;
                state_next  = ST_EXEC;
                case (opcode)
                    OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OPIMM, OPC_OP: is_wr_next = 1'b1;
                    OPC_BRANCH, OPC_MISCMEM: begin end
                    OPC_LOAD: begin
                        is_mem_next = 1'b1;
                        is_wr_next  = 1'b1;
                    end
                    OPC_STORE: is_mem_next = 1'b1;
                    // SYSTEM skips EXEC and retires straight away, then halts
                    OPC_SYSTEM: begin
                        is_sys_next = 1'b1;
                        state_next  = ST_WB;
                    end
                    default: begin
                        trap_next  = 1'b1;
                        state_next = ST_STOP;
                    end
                endcase
            end
            ST_EXEC: state_next = is_mem_reg ? ST_MEM : ST_WB;
            ST_MEM: begin
                if (dmem_req_ready) begin
                    state_next = dmem_resp_valid ? ST_WB : ST_WAIT_D;
                end else begin
                    wait_tick = 1'b1;
                end
            end
            ST_WAIT_D: begin
                if (dmem_resp_valid) begin
                    state_next = ST_WB;
                end else begin
                    wait_tick = 1'b1;
                end
            end
            ST_WB: begin
                if (is_sys_reg) begin
                    halted_next = 1'b1;
                    state_next  = ST_STOP;
                end else begin
                    state_next = ST_FETCH;
                end
            end
            default: begin end
        endcase
        // Any cycle that is not a stalled wait is either a transition or a non-waiting state,
        // so the counter restarts from zero on every entry into a waiting state.
        if (wait_tick) begin
            cnt_next = cnt_reg + 8'd1;
            if (TIMEOUT != 0 && cnt_next == TIMEOUT_CNT) begin
                trap_next  = 1'b1;
                state_next = ST_STOP;
            end
        end
    end

`ifdef RISCV_SEQ_CTRL_INSTRET_EN
    logic [63:0] instret_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            instret_reg <= 64'd0;
        end else if (state_reg == ST_WB) begin
            instret_reg <= instret_reg + 64'd1;
        end
    end

    assign instret = instret_reg;
`endif

    assign state          = state_reg;
    assign pc             = pc_reg;
    assign insn           = insn_reg;
    assign trap           = trap_reg;
    assign halted         = halted_reg;
    assign imem_req_valid = (state_reg == ST_FETCH);
    assign dmem_req_valid = (state_reg == ST_MEM);
    assign pc_we          = (state_reg == ST_WB);
    assign rf_we          = (state_reg == ST_WB) && is_wr_reg;

endmodule

// File: tb/tb_riscv_seq_ctrl.sv
// Bench for riscv_seq_ctrl: expected retires (pc, rf_we) are queued as instructions are issued
// and popped when pc_we pulses; each scenario task also checks state sequencing inline.
`timescale 1ns/1ps
module tb_riscv_seq_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int          TO     = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'd0;
    logic [31:0] insn;
    logic [6:0]  opcode;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        dmem_req_valid;
    logic        dmem_req_ready = 1'b0;
    logic        dmem_resp_valid = 1'b0;
    logic        rf_we;
    logic        pc_we;
    logic [2:0]  state;
    logic        trap;
    logic        halted;
`ifdef RISCV_SEQ_CTRL_INSTRET_EN
    logic [63:0] instret;
`endif

    logic [31:0] pc_step = 32'd4;
    logic [31:0] pc_model;

    typedef struct {
        logic [31:0] pc_before;
        logic        rf;
    } retire_t;

    retire_t sb[$];
    int checks = 0;
    int errors = 0;

    assign opcode  = insn[6:0];
    assign pc_next = pc + pc_step;

    riscv_seq_ctrl #(.RESET_PC(RST_PC), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .insn(insn), .opcode(opcode), .pc(pc), .pc_next(pc_next),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_resp_valid(dmem_resp_valid),
        .rf_we(rf_we), .pc_we(pc_we), .state(state),
`ifdef RISCV_SEQ_CTRL_INSTRET_EN
        .instret(instret),
`endif
        .trap(trap), .halted(halted)
    );

    always #5 clk = ~clk;

    // Scoreboard consumer: every pc_we pulse must match the oldest queued retire
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (rf_we && !pc_we) begin
                errors++;
                $display("FAIL rf_we_outside_wb: rf_we=%0b pc_we=%0b state=%0d, required rf_we only with pc_we", rf_we, pc_we, state);
            end
            if (pc_we) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_retire: pc=%h insn=%h, required no retire", pc, insn);
                end else begin
                    retire_t e;
                    e = sb.pop_front();
                    if (pc !== e.pc_before || rf_we !== e.rf) begin
                        errors++;
                        $display("FAIL retire: pc=%h rf_we=%0b, required pc=%h rf_we=%0b", pc, rf_we, e.pc_before, e.rf);
                    end
                    $display("retire pc=%h insn=%h rf_we=%0b", pc, insn, rf_we);
                end
            end
        end
    end

    task automatic apply_reset;
        rst = 1'b1;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0;
        dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0;
        pc_step = 32'd4;
        repeat (2) @(negedge clk);
        sb.delete();
        rst = 1'b0;
        pc_model = RST_PC;
    endtask

    // Called at a negedge in FETCH; returns at the following negedge (DECODE)
    task automatic drive_fetch(input logic [31:0] data);
        imem_req_ready = 1'b1; imem_resp_valid = 1'b1; imem_resp_data = data;
        @(negedge clk);
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0;
    endtask

    task automatic test_reset;
        logic [72:0] got, exp;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        got = {state, pc, insn, rf_we, pc_we, trap, halted, imem_req_valid, dmem_req_valid};
        exp = {3'd0, RST_PC, 32'h0000_0013, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset_values: got=%h required=%h", got, exp);
        end
`ifdef RISCV_SEQ_CTRL_INSTRET_EN
        checks++;
        if (instret !== 64'd0) begin
            errors++;
            $display("FAIL reset_instret: got=%0d required=0", instret);
        end
`endif
        rst = 1'b0;
        pc_model = RST_PC;
        $display("reset pc=%h state=%0d", pc, state);
    endtask

    // addi with a one-cycle imem response: FETCH, WAIT_I, DECODE, EXEC, WB -> refetch after 5 edges
    task automatic test_addi;
        logic [2:0] exp_st [5];
        int pulses;
        exp_st = '{3'd1, 3'd2, 3'd3, 3'd6, 3'd0};
        pulses = 0;
        sb.push_back(retire_t'{pc_model, 1'b1});
        imem_req_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 0) begin
                imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h0050_0093;
            end else if (c == 1) begin
                imem_resp_valid = 1'b0;
            end
            if (pc_we && rf_we) pulses++;
            checks++;
            if (state !== exp_st[c]) begin
                errors++;
                $display("FAIL addi_state c=%0d: got=%0d required=%0d", c, state, exp_st[c]);
            end
            checks++;
            if (imem_req_valid !== (c == 4)) begin
                errors++;
                $display("FAIL addi_refetch c=%0d: imem_req_valid=%0b required=%0b", c, imem_req_valid, (c == 4));
            end
        end
        pc_model = pc_model + 32'd4;
        checks++;
        if (pulses != 1 || pc !== pc_model || insn !== 32'h0050_0093) begin
            errors++;
            $display("FAIL addi_result: pulses=%0d pc=%h insn=%h, required 1 %h 00500093", pulses, pc, insn, pc_model);
        end
        $display("addi done pc=%h", pc);
    endtask

    task automatic test_load;
        logic [2:0] exp_st [7];
        int pulses;
        exp_st = '{3'd4, 3'd4, 3'd4, 3'd4, 3'd5, 3'd5, 3'd6};
        pulses = 0;
        sb.push_back(retire_t'{pc_model, 1'b1});
        drive_fetch(32'h0000_A103);
        @(negedge clk);
        checks++;
        if (state !== 3'd3) begin
            errors++;
            $display("FAIL load_exec: got=%0d required=3", state);
        end
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (rf_we) pulses++;
            checks++;
            if (state !== exp_st[c] || dmem_req_valid !== (exp_st[c] == 3'd4)) begin
                errors++;
                $display("FAIL load_state c=%0d: state=%0d dmem_req_valid=%0b required=%0d %0b", c, state, dmem_req_valid, exp_st[c], (exp_st[c] == 3'd4));
            end
            dmem_req_ready  = (c == 3);
            dmem_resp_valid = (c == 5);
        end
        dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0;
        @(negedge clk);
        pc_model = pc_model + 32'd4;
        checks++;
        if (pulses != 1 || state !== 3'd0 || pc !== pc_model) begin
            errors++;
            $display("FAIL load_result: rf_pulses=%0d state=%0d pc=%h, required 1 0 %h", pulses, state, pc, pc_model);
        end
        $display("load done pc=%h", pc);
    endtask

    task automatic test_store;
        logic [2:0] exp_st [4];
        int rf_pulses, pc_pulses;
        exp_st = '{3'd3, 3'd4, 3'd6, 3'd0};
        rf_pulses = 0; pc_pulses = 0;
        sb.push_back(retire_t'{pc_model, 1'b0});
        drive_fetch(32'h0020_A023);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (rf_we) rf_pulses++;
            if (pc_we) pc_pulses++;
            checks++;
            if (state !== exp_st[c]) begin
                errors++;
                $display("FAIL store_state c=%0d: got=%0d required=%0d", c, state, exp_st[c]);
            end
            dmem_req_ready  = (c == 1);
            dmem_resp_valid = (c == 1);
        end
        pc_model = pc_model + 32'd4;
        checks++;
        if (rf_pulses != 0 || pc_pulses != 1 || pc !== pc_model) begin
            errors++;
            $display("FAIL store_result: rf=%0d pc_we=%0d pc=%h, required 0 1 %h", rf_pulses, pc_pulses, pc, pc_model);
        end
        $display("store done pc=%h", pc);
    endtask

    // Mixed opcode classes, back to back, including a jump that makes the PC wrap past 2^32
    task automatic test_back_to_back;
        logic [31:0] data [6];
        logic [31:0] tgt  [6];
        logic        rf   [6];
        data = '{32'h1234_50B7, 32'h0020_8463, 32'h0000_000F, 32'h0080_00EF, 32'h0000_0117, 32'h0000_8067};
        tgt  = '{32'h0000_0110, 32'h0000_0130, 32'h0000_0134, 32'hFFFF_FFFC, 32'h0000_0004, 32'h0000_0008};
        rf   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 6; i++) begin
            sb.push_back(retire_t'{pc_model, rf[i]});
            pc_step = tgt[i] - pc_model;
            drive_fetch(data[i]);
            @(negedge clk);
            @(negedge clk);
            checks++;
            if (state !== 3'd6) begin
                errors++;
                $display("FAIL b2b_wb i=%0d: state=%0d required=6", i, state);
            end
            @(negedge clk);
            checks++;
            if (state !== 3'd0 || pc !== tgt[i]) begin
                errors++;
                $display("FAIL b2b_pc i=%0d: state=%0d pc=%h, required 0 %h", i, state, pc, tgt[i]);
            end
            pc_model = tgt[i];
        end
        pc_step = 32'd4;
        $display("back_to_back done pc=%h", pc);
    endtask

    task automatic test_illegal;
        drive_fetch(32'hFFFF_FFFF);
        @(negedge clk);
        checks++;
        if (state !== 3'd7 || trap !== 1'b1 || pc !== pc_model) begin
            errors++;
            $display("FAIL illegal_trap: state=%0d trap=%0b pc=%h, required 7 1 %h", state, trap, pc, pc_model);
        end
        for (int c = 0; c < 20; c++) begin
            imem_req_ready  = 1'b1;
            imem_resp_valid = 1'($urandom_range(0, 1));
            imem_resp_data  = $urandom;
            dmem_req_ready  = 1'($urandom_range(0, 1));
            dmem_resp_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++;
            if (imem_req_valid !== 1'b0 || dmem_req_valid !== 1'b0 || state !== 3'd7 ||
                pc !== pc_model || insn !== 32'hFFFF_FFFF || trap !== 1'b1) begin
                errors++;
                $display("FAIL stop_hold c=%0d: ireq=%0b dreq=%0b state=%0d pc=%h insn=%h trap=%0b, required 0 0 7 %h ffffffff 1",
                         c, imem_req_valid, dmem_req_valid, state, pc, insn, trap, pc_model);
            end
        end
        apply_reset;
        checks++;
        if (pc !== RST_PC || trap !== 1'b0 || state !== 3'd0) begin
            errors++;
            $display("FAIL illegal_reset: pc=%h trap=%0b state=%0d, required %h 0 0", pc, trap, state, RST_PC);
        end
        $display("illegal done trap=%0b", trap);
    endtask

    task automatic test_timeout;
        for (int e = 1; e <= 4; e++) begin
            @(negedge clk);
            checks++;
            if (trap !== (e == 4) || state !== ((e == 4) ? 3'd7 : 3'd0)) begin
                errors++;
                $display("FAIL timeout e=%0d: trap=%0b state=%0d, required %0b %0d", e, trap, state, (e == 4), ((e == 4) ? 7 : 0));
            end
        end
        apply_reset;
        drive_fetch(32'h0000_A103);
        @(negedge clk);
        @(negedge clk);
        dmem_req_ready = 1'b1;
        @(negedge clk);
        dmem_req_ready = 1'b0;
        checks++;
        if (state !== 3'd5) begin
            errors++;
            $display("FAIL timeout_waitd: state=%0d required=5", state);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (state !== 3'd0 || rf_we !== 1'b0 || pc_we !== 1'b0 || pc !== RST_PC || trap !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_waitd: state=%0d rf_we=%0b pc_we=%0b pc=%h trap=%0b, required 0 0 0 %h 0",
                     state, rf_we, pc_we, pc, trap, RST_PC);
        end
        rst = 1'b0;
        dmem_resp_valid = 1'b1; imem_resp_valid = 1'b1; imem_resp_data = 32'hDEAD_BEEF;
        @(negedge clk);
        dmem_resp_valid = 1'b0; imem_resp_valid = 1'b0;
        checks++;
        if (state !== 3'd0 || insn !== 32'h0000_0013) begin
            errors++;
            $display("FAIL stale_resp: state=%0d insn=%h, required 0 00000013", state, insn);
        end
        $display("timeout done state=%0d", state);
    endtask

    task automatic test_ecall;
        logic [31:0] data [3];
        data = '{32'h0050_0093, 32'h0060_0113, 32'h0020_81B3};
        apply_reset;
        for (int i = 0; i < 3; i++) begin
            sb.push_back(retire_t'{pc_model, 1'b1});
            drive_fetch(data[i]);
            repeat (3) @(negedge clk);
            pc_model = pc_model + 32'd4;
        end
        checks++;
        if (pc !== pc_model || state !== 3'd0) begin
            errors++;
            $display("FAIL ecall_prefix: pc=%h state=%0d, required %h 0", pc, state, pc_model);
        end
        sb.push_back(retire_t'{pc_model, 1'b0});
        drive_fetch(32'h0000_0073);
        @(negedge clk);
        checks++;
        if (state !== 3'd6 || halted !== 1'b0) begin
            errors++;
            $display("FAIL ecall_wb: state=%0d halted=%0b, required 6 0", state, halted);
        end
        @(negedge clk);
        pc_model = pc_model + 32'd4;
        checks++;
        if (state !== 3'd7 || halted !== 1'b1 || trap !== 1'b0 || pc !== pc_model) begin
            errors++;
            $display("FAIL ecall_halt: state=%0d halted=%0b trap=%0b pc=%h, required 7 1 0 %h", state, halted, trap, pc, pc_model);
        end
`ifdef RISCV_SEQ_CTRL_INSTRET_EN
        checks++;
        if (instret !== 64'd4) begin
            errors++;
            $display("FAIL ecall_instret: got=%0d required=4", instret);
        end
`endif
        repeat (5) @(negedge clk);
        checks++;
        if (state !== 3'd7 || imem_req_valid !== 1'b0 || halted !== 1'b1) begin
            errors++;
            $display("FAIL halt_hold: state=%0d ireq=%0b halted=%0b, required 7 0 1", state, imem_req_valid, halted);
        end
        $display("ecall done halted=%0b", halted);
    endtask

    initial begin
        test_reset;
        test_addi;
        test_load;
        test_store;
        test_back_to_back;
        test_illegal;
        test_timeout;
        test_ecall;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d retires outstanding, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
